pwm_duty_ramp: RTL and testbench
================================

// Module: pwm_duty_ramp
// PURPOSE
//  Downstream consumer of the free-running 1..N binary counter. Compares the counter value
//  against a working duty value to produce a registered PWM output.
//  New target duties arrive through a valid/ready handshake. The working duty ramps toward
//  the target by STEP once per counter period, giving glitch-free soft-start/soft-stop.
// PARAMETERS
//  W     8   width of counter value, period and duty
//  STEP  16  max change of working duty per period boundary; legal range 1..2^W-1
// PORTS
//  clk         in   1  single clock; all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  cnt_in      in   W  counter value from upstream counter; counts 1..period_in then wraps to 1
//  period_in   in   W  terminal count; same value driven to the upstream counter
//  duty_valid  in   1  new target duty offered
//  duty_data   in   W  target duty, in counts per period
//  duty_ready  out  1  block can accept a target this cycle
//  duty_cur    out  W  working duty currently applied
//  ramp_busy   out  1  high while working duty != latched target
//  period_tick out  1  one-cycle pulse, registered copy of the boundary condition
//  pwm_out     out  1  PWM output
// BEHAVIOUR
//  - Reset (sync): pwm_out=0, duty_cur=0, target=0, period_tick=0, state=IDLE.
//    duty_ready=1 and ramp_busy=0 from the first cycle after reset.
//    Reset mid-ramp discards the ramp immediately; no partial update survives.
//  - Boundary condition: boundary = (cnt_in == period_in). Equality only; no other period decode.
//  - period_tick: period_tick(k+1) = boundary(k).
//  - PWM output: pwm_out(k+1) = (cnt_in(k) <= duty_cur(k)).
//    duty_cur=0 gives constant low.
//    duty_cur >= period_in gives constant high.
//    High time per period = min(duty_cur, period_in) cycles.
//  - FSM states:
//    IDLE: duty_ready=1, ramp_busy=0.
//      On duty_valid&&duty_ready, latch target=duty_data.
//      If duty_data != duty_cur, go to RAMP next cycle; else stay in IDLE.
//      An accept that coincides with a boundary does not move duty_cur that boundary;
//      the ramp starts at the next boundary.
//    RAMP: duty_ready=0, ramp_busy=1. duty_valid is ignored; the source must hold it.
//      At each boundary: duty_cur <= duty_cur +/- min(STEP, |target-duty_cur|).
//      When the update lands on target, return to IDLE on the following cycle.
//  - duty_cur changes only in the cycle after a boundary, so a PWM period never sees a
//    mid-period duty change.
//  - Arithmetic: compute the difference in W+1 bits. Steps are clamped so duty_cur never
//    overshoots the target and never wraps past 0 or 2^W-1.
//  - period_in change mid-period: takes effect at the next equality match. No correction
//    is applied to the current period.
// TESTING  (W=8, STEP=16, period_in=100, upstream counter free-running)
//  1 Reset: assert reset 3 cycles -> pwm_out=0, duty_cur=0, duty_ready=1, ramp_busy=0,
//    period_tick=0.
//  2 Up-ramp: accept duty 50 -> duty_cur steps 16,32,48,50 on 4 successive boundaries;
//    duty_ready=0 until the cycle after reaching 50; then pwm_out is high for exactly 50
//    of every 100 cycles.
//  3 Down-ramp from 50: accept duty 10 -> duty_cur 34,18,10; STEP clamp verified at the
//    last step.
//  4 Extremes:
//    duty 0 -> pwm_out constantly 0.
//    duty 100 -> pwm_out constantly 1.
//    duty 200 (> period) -> pwm_out constantly 1, with no wrap in duty_cur.
//  5 Busy handshake: raise duty_valid=1, duty_data=80 mid-ramp -> no accept while
//    duty_ready=0. Accepted in the first IDLE cycle, then a new ramp begins.
//    Same-value load (target==duty_cur) stays in IDLE.
//  6 Reset mid-ramp (duty_cur=32, target 50) -> next cycle duty_cur=0, pwm_out=0,
//    state IDLE, no further steps occur.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - PWM comparator with soft-ramped working duty
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   cnt_in, period_in   upstream counter value (1..period_in) and its terminal count
//   duty_valid/_data    target duty offer; duty_ready accepts it
//   duty_cur            working duty applied to the comparator
//   ramp_busy           working duty still moving toward the latched target
//   period_tick         registered boundary pulse
//   pwm_out             registered PWM output
module pwm_duty_ramp #(
  parameter int W    = 8,
  parameter int STEP = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] cnt_in,
  input  logic [W-1:0] period_in,
  input  logic         duty_valid,
  input  logic [W-1:0] duty_data,
  output logic         duty_ready,
  output logic [W-1:0] duty_cur,
  output logic         ramp_busy,
  output logic         period_tick,
  output logic         pwm_out
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [W:0] STEP_W = (W+1)'(STEP);

  state_t       state_q, state_d;
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] duty_q, duty_d;
  logic         pwm_q, tick_q;
  logic         boundary;
  logic [W:0]   diff, mag, step, duty_next;

  assign boundary = (cnt_in == period_in);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    duty_d     = duty_q;
    duty_ready = 1'b0;
    ramp_busy  = 1'b0;
    // Signed difference in W+1 bits; the top bit set means target is below duty.
    diff       = {1'b0, target_q} - {1'b0, duty_q};
    mag        = diff[W] ? (~diff + 1'b1) : diff;
    // Clamp to the remaining distance so the step never overshoots or wraps.
    step       = (mag < STEP_W) ? mag : STEP_W;
    duty_next  = diff[W] ? ({1'b0, duty_q} - step) : ({1'b0, duty_q} + step);
    case (state_q)
      IDLE: begin
        duty_ready = 1'b1;
        if (duty_valid) begin
          target_d = duty_data;
          if (duty_data != duty_q) begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        ramp_busy = 1'b1;
        if (boundary) begin
          duty_d = duty_next[W-1:0];
          if (duty_next[W-1:0] == target_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      pwm_q    <= (cnt_in <= duty_q);
      tick_q   <= boundary;
    end
  end

  assign duty_cur    = duty_q;
  assign period_tick = tick_q;
  assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - self-checking bench for pwm_duty_ramp
module tb_pwm_duty_ramp;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cnt_in = 8'd1;
  logic [7:0] period_in = 8'd100;
  logic       duty_valid = 1'b0;
  logic [7:0] duty_data = 8'd0;
  logic       duty_ready;
  logic [7:0] duty_cur;
  logic       ramp_busy;
  logic       period_tick;
  logic       pwm_out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] cur;
    logic       ready;
    logic       busy;
    logic       tick;
    logic       pwm;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int duty;
    int n;
    int seq[8];
    int hi;
  } vec_t;
  vec_t tbl[6];

  int m_cur = 0;
  int m_tgt = 0;
  bit m_ramp = 1'b0;

  pwm_duty_ramp #(.W(8), .STEP(16)) dut (
    .clk(clk),
    .reset(reset),
    .cnt_in(cnt_in),
    .period_in(period_in),
    .duty_valid(duty_valid),
    .duty_data(duty_data),
    .duty_ready(duty_ready),
    .duty_cur(duty_cur),
    .ramp_busy(ramp_busy),
    .period_tick(period_tick),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: predict the post-edge outputs from the current inputs, push,
  // then pop and compare once the DUT has clocked.
  task automatic cyc();
    exp_t e;
    int d;
    if (reset) begin
      m_cur = 0; m_tgt = 0; m_ramp = 1'b0;
      e.pwm = 1'b0; e.tick = 1'b0;
    end else begin
      e.pwm  = (int'(cnt_in) <= m_cur);
      e.tick = (cnt_in == period_in);
      if (!m_ramp) begin
        if (duty_valid) begin
          m_tgt  = int'(duty_data);
          m_ramp = (m_tgt != m_cur);
        end
      end else if (cnt_in == period_in) begin
        d = m_tgt - m_cur;
        if (d > 16) m_cur = m_cur + 16;
        else if (d < -16) m_cur = m_cur - 16;
        else m_cur = m_tgt;
        if (m_cur == m_tgt) m_ramp = 1'b0;
      end
    end
    e.cur   = m_cur[7:0];
    e.ready = !m_ramp;
    e.busy  = (m_cur != m_tgt);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("sb_duty_cur", 32'(duty_cur), 32'(e.cur));
    check("sb_duty_ready", 32'(duty_ready), 32'(e.ready));
    check("sb_ramp_busy", 32'(ramp_busy), 32'(e.busy));
    check("sb_period_tick", 32'(period_tick), 32'(e.tick));
    check("sb_pwm_out", 32'(pwm_out), 32'(e.pwm));
    cnt_in = (cnt_in == period_in) ? 8'd1 : cnt_in + 8'd1;
  endtask

  task automatic wait_ready(input int lim);
    int k = 0;
    while (duty_ready !== 1'b1 && k < lim) begin
      cyc();
      k++;
    end
    check("wait_ready_bound", 32'(duty_ready), 32'd1);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (ramp_busy !== 1'b0 && k < lim) begin
      cyc();
      k++;
    end
    check("wait_idle_bound", 32'(ramp_busy), 32'd0);
  endtask

  task automatic run_entry(input int i);
    int got[8];
    int n = 0;
    int k = 0;
    int prev;
    int hi = 0;
    for (int j = 0; j < 8; j++) got[j] = -1;
    wait_ready(600);
    duty_valid = 1'b1;
    duty_data  = 8'(tbl[i].duty);
    cyc();
    duty_valid = 1'b0;
    prev = int'(duty_cur);
    while (ramp_busy === 1'b1 && k < 2000) begin
      cyc();
      k++;
      if (int'(duty_cur) != prev) begin
        if (n < 8) got[n] = int'(duty_cur);
        n++;
        prev = int'(duty_cur);
      end
    end
    check($sformatf("v%0d_ramp_bound", i), 32'(ramp_busy), 32'd0);
    check($sformatf("v%0d_nsteps", i), 32'(n), 32'(tbl[i].n));
    for (int j = 0; j < tbl[i].n; j++)
      check($sformatf("v%0d_step%0d", i, j), 32'(got[j]), 32'(tbl[i].seq[j]));
    check($sformatf("v%0d_final_duty", i), 32'(duty_cur), 32'(tbl[i].duty));
    k = 0;
    while (period_tick !== 1'b1 && k < 200) begin
      cyc();
      k++;
    end
    check($sformatf("v%0d_tick_bound", i), 32'(period_tick), 32'd1);
    repeat (100) begin
      cyc();
      hi += int'(pwm_out);
    end
    check($sformatf("v%0d_high_count", i), 32'(hi), 32'(tbl[i].hi));
  endtask

  initial begin
    int k;
    tbl[0] = '{50,  4, '{16, 32, 48, 50, 0, 0, 0, 0}, 50};
    tbl[1] = '{10,  3, '{34, 18, 10, 0, 0, 0, 0, 0}, 10};
    tbl[2] = '{0,   1, '{0, 0, 0, 0, 0, 0, 0, 0}, 0};
    tbl[3] = '{100, 7, '{16, 32, 48, 64, 80, 96, 100, 0}, 100};
    tbl[4] = '{200, 7, '{116, 132, 148, 164, 180, 196, 200, 0}, 100};
    tbl[5] = '{200, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 100};

    reset = 1'b1;
    repeat (3) cyc();
    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_duty_cur", 32'(duty_cur), 32'd0);
    check("rst_duty_ready", 32'(duty_ready), 32'd1);
    check("rst_ramp_busy", 32'(ramp_busy), 32'd0);
    check("rst_period_tick", 32'(period_tick), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_entry(i);

    // Accept on a boundary cycle: no step that boundary; then a held offer mid-ramp.
    wait_ready(600);
    k = 0;
    while (cnt_in != period_in && k < 200) begin
      cyc();
      k++;
    end
    duty_valid = 1'b1;
    duty_data  = 8'd170;
    cyc();
    check("coinc_duty_cur", 32'(duty_cur), 32'd200);
    check("coinc_busy", 32'(ramp_busy), 32'd1);
    check("coinc_ready", 32'(duty_ready), 32'd0);
    duty_data = 8'd80;
    wait_ready(1000);
    check("busy_first_target_done", 32'(duty_cur), 32'd170);
    cyc();
    check("busy_accept_after_idle", 32'(ramp_busy), 32'd1);
    duty_valid = 1'b0;
    wait_idle(1500);
    check("busy_final_duty", 32'(duty_cur), 32'd80);

    // Same-value load stays idle.
    wait_ready(600);
    duty_valid = 1'b1;
    duty_data  = 8'd80;
    cyc();
    duty_valid = 1'b0;
    check("same_busy", 32'(ramp_busy), 32'd0);
    check("same_ready", 32'(duty_ready), 32'd1);
    repeat (150) cyc();
    check("same_duty_hold", 32'(duty_cur), 32'd80);

    // Reset in the middle of a ramp toward 50.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    duty_valid = 1'b1;
    duty_data  = 8'd50;
    cyc();
    duty_valid = 1'b0;
    k = 0;
    while (duty_cur !== 8'd32 && k < 500) begin
      cyc();
      k++;
    end
    check("midramp_reach_32", 32'(duty_cur), 32'd32);
    reset = 1'b1;
    cyc();
    check("midrst_duty_cur", 32'(duty_cur), 32'd0);
    check("midrst_pwm_out", 32'(pwm_out), 32'd0);
    check("midrst_ready", 32'(duty_ready), 32'd1);
    check("midrst_busy", 32'(ramp_busy), 32'd0);
    reset = 1'b0;
    repeat (300) cyc();
    check("midrst_no_steps", 32'(duty_cur), 32'd0);
    check("midrst_still_idle", 32'(ramp_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
